id_operand_stage: RTL and testbench

Parametrised decode-side operand collector and ID→EX pipeline register for the riscv core. It holds the register file, a per-register pending-writer counter scoreboard, N-way priority forwarding and read-port stall logic. Operands are delivered to EX over a valid/ready handshake. It replaces the fixed two-port, fixed-forwarding operand path. Unlike that path, it supports multiple outstanding writers per register, squash accounting and EX backpressure.

---
 rtl/id_operand_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ID-side operand collector and ID->EX pipeline register.
// Holds the register file and a per-register count of in-flight writers.
// Each source port resolves its operand from the youngest forwarding stage
// that claims the register, then the retire bypass, then the register file.
// The collected operands go to EX over a valid/ready handshake.
module id_operand_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRPORT = 2,
    parameter int NFWD   = 3,
    parameter int PEND_W = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   instr_valid,
    input  logic [NRPORT-1:0]      rs_en,
    input  logic [NRPORT*5-1:0]    rs_addr,
    input  logic                   rd_en,
    input  logic [4:0]             rd_addr,
    output logic                   issue_ready,
    input  logic                   flush,
    input  logic [NFWD-1:0]        fwd_vld,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic [NFWD*5-1:0]      fwd_addr,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   wb_en,
    input  logic [4:0]             wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   kill_en,
    input  logic [4:0]             kill_addr,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [NRPORT*XLEN-1:0] ex_src,
    output logic                   ex_rd_en,
    output logic [4:0]             ex_rd_addr
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [XLEN-1:0]          rf_reg      [NREG];
    logic [PEND_W-1:0]        pending_reg [NREG];
    logic [PEND_W-1:0]        pend_next   [NREG];
    logic [NREG-1:0]          underflow;

    logic                     ex_valid_reg;
    logic [NRPORT*XLEN-1:0]   ex_src_reg;
    logic                     ex_rd_en_reg;
    logic [4:0]               ex_rd_addr_reg;

    logic [NRPORT-1:0]        port_ready;
    logic [NRPORT*XLEN-1:0]   port_data;
    logic                     rd_full;
    logic                     fire;

    // Apply one cycle's net writer change: a single increment and up to three
    // decrements (retire, kill, flushed EX entry); clamps at 0 and at full.
    function automatic logic [PEND_W-1:0] pend_update(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic [1:0]        decs
    );
        logic [PEND_W+1:0] c;
        logic [PEND_W+1:0] d;
        c = {2'b00, cur};
        if (inc && decs == 2'd0) begin
            return (cur == PEND_MAX) ? cur : cur + PEND_ONE;
        end else if (decs > {1'b0, inc}) begin
            d = (PEND_W+2)'(decs - {1'b0, inc});
            return (c > d) ? PEND_W'(c - d) : '0;
        end else begin
            return cur;
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NRPORT; gi++) begin : g_port
            logic [4:0]      src_addr;
            logic            p_ready;
            logic [XLEN-1:0] p_data;
            logic            fwd_hit;

            assign src_addr = rs_addr[gi*5 +: 5];

            // Resolve one source operand: x0, youngest forwarding match, retire bypass, RF.
            always_comb begin
                fwd_hit = 1'b0;
                p_ready = 1'b1;
                p_data  = '0;
                if (rs_en[gi] && src_addr != 5'd0) begin
                    for (int c = 0; c < NFWD; c++) begin
                        if (!fwd_hit && fwd_vld[c] && fwd_addr[c*5 +: 5] == src_addr) begin
                            fwd_hit = 1'b1;
                            p_ready = fwd_rdy[c];
                            p_data  = fwd_data[c*XLEN +: XLEN];
                        end
                    end
                    if (!fwd_hit) begin
                        if (wb_en && wb_addr == src_addr && pending_reg[src_addr] <= PEND_ONE) begin
                            p_data = wb_data;
                        end else if (pending_reg[src_addr] == '0) begin
                            p_data = rf_reg[src_addr];
                        end else begin
                            p_ready = 1'b0;
                        end
                    end
                end
            end

            assign port_ready[gi]             = p_ready;
            assign port_data[gi*XLEN +: XLEN] = p_data;
        end
    endgenerate

    // A new writer cannot be tracked once its destination counter is full.
    assign rd_full     = rd_en && rd_addr != 5'd0 && pending_reg[rd_addr] == PEND_MAX;
    assign issue_ready = !flush && (&port_ready) && !rd_full && (!ex_valid_reg || ex_ready);
    assign fire        = instr_valid && issue_ready;

    // Sum every writer event per register so simultaneous inc/dec net out once.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic       inc;
            logic [1:0] decs;
            inc  = (r != 0) && fire && rd_en && rd_addr == 5'(r);
            decs = 2'(((r != 0) && wb_en && wb_addr == 5'(r)) ? 1 : 0)
                 + 2'(((r != 0) && kill_en && kill_addr == 5'(r)) ? 1 : 0)
                 + 2'(((r != 0) && flush && ex_valid_reg && ex_rd_en_reg && ex_rd_addr_reg == 5'(r)) ? 1 : 0);
            pend_next[r] = pend_update(pending_reg[r], inc, decs);
            underflow[r] = (pending_reg[r] == '0) && (decs > {1'b0, inc});
        end
    end

    // Pending-writer counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) pending_reg[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) pending_reg[r] <= pend_next[r];
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) rf_reg[r] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            rf_reg[wb_addr] <= wb_data;
        end
    end

    // ID->EX register: flush drops the entry, fire loads it, handshake empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_reg   <= 1'b0;
            ex_src_reg     <= '0;
            ex_rd_en_reg   <= 1'b0;
            ex_rd_addr_reg <= 5'd0;
        end else if (flush) begin
            ex_valid_reg   <= 1'b0;
        end else if (fire) begin
            ex_valid_reg   <= 1'b1;
            ex_src_reg     <= port_data;
            ex_rd_en_reg   <= rd_en;
            ex_rd_addr_reg <= rd_addr;
        end else if (ex_ready) begin
            ex_valid_reg   <= 1'b0;
        end
    end

    // A writer event must never retire a register with no writer in flight.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (underflow == '0);
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_src     = ex_src_reg;
    assign ex_rd_en   = ex_rd_en_reg;
    assign ex_rd_addr = ex_rd_addr_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with an expected-payload scoreboard.
module tb_id_operand_stage;

    localparam int XLEN = 32;
    localparam int NRPORT = 2;
    localparam int NFWD = 3;

    logic                   clk;
    logic                   reset_n;
    logic                   instr_valid;
    logic [NRPORT-1:0]      rs_en;
    logic [NRPORT*5-1:0]    rs_addr;
    logic                   rd_en;
    logic [4:0]             rd_addr;
    logic                   issue_ready;
    logic                   flush;
    logic [NFWD-1:0]        fwd_vld;
    logic [NFWD-1:0]        fwd_rdy;
    logic [NFWD*5-1:0]      fwd_addr;
    logic [NFWD*XLEN-1:0]   fwd_data;
    logic                   wb_en;
    logic [4:0]             wb_addr;
    logic [XLEN-1:0]        wb_data;
    logic                   kill_en;
    logic [4:0]             kill_addr;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [NRPORT*XLEN-1:0] ex_src;
    logic                   ex_rd_en;
    logic [4:0]             ex_rd_addr;

    typedef struct {
        logic [XLEN-1:0] s0;
        logic [XLEN-1:0] s1;
        logic            rde;
        logic [4:0]      rda;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    id_operand_stage dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
        .rs_en(rs_en), .rs_addr(rs_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .issue_ready(issue_ready), .flush(flush),
        .fwd_vld(fwd_vld), .fwd_rdy(fwd_rdy), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .kill_en(kill_en), .kill_addr(kill_addr),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_src(ex_src),
        .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic push(input logic [XLEN-1:0] s0, input logic [XLEN-1:0] s1,
                        input logic rde, input logic [4:0] rda);
        exp_t e;
        e.s0 = s0; e.s1 = s1; e.rde = rde; e.rda = rda;
        sb.push_back(e);
    endtask

    task automatic idle();
        instr_valid = 1'b0; rs_en = '0; rs_addr = '0; rd_en = 1'b0; rd_addr = 5'd0;
        flush = 1'b0; fwd_vld = '0; fwd_rdy = '0; fwd_addr = '0; fwd_data = '0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0; kill_en = 1'b0; kill_addr = 5'd0;
        ex_ready = 1'b1;
    endtask

    // One clock: compare a payload being handed to EX, then advance to the next negedge.
    task automatic cyc();
        exp_t e;
        #1;
        if (ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ex_valid", {63'd0, ex_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ex_src0", {32'd0, ex_src[31:0]}, {32'd0, e.s0});
                check("ex_src1", {32'd0, ex_src[63:32]}, {32'd0, e.s1});
                check("ex_rd_en", {63'd0, ex_rd_en}, {63'd0, e.rde});
                check("ex_rd_addr", {59'd0, ex_rd_addr}, {59'd0, e.rda});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ex_src", {32'd0, ex_src}, 64'd0);
        check("rst_ex_rd", {58'd0, ex_rd_en, ex_rd_addr}, 64'd0);
        check("rst_pend5", {62'd0, dut.pending_reg[5]}, 64'd0);
        reset_n = 1'b1;
        cyc();

        // x0 operands, rd=x5
        instr_valid = 1'b1; rs_en = 2'b11; rs_addr = '0; rd_en = 1'b1; rd_addr = 5'd5;
        #1 check("t1_issue_ready", {63'd0, issue_ready}, 64'd1);
        push(32'd0, 32'd0, 1'b1, 5'd5);
        cyc();
        idle();
        #1 check("t1_ex_valid", {63'd0, ex_valid}, 64'd1);
        check("t1_pend5", {62'd0, dut.pending_reg[5]}, 64'd1);
        cyc();

        // youngest forwarding channel wins even when it is not ready
        instr_valid = 1'b1; rs_en = 2'b01; rs_addr[4:0] = 5'd5;
        fwd_vld = 3'b011; fwd_addr[4:0] = 5'd5; fwd_addr[9:5] = 5'd5;
        fwd_rdy = 3'b010; fwd_data[63:32] = 32'hA5;
        #1 check("t2_stall_ch0", {63'd0, issue_ready}, 64'd0);
        cyc();
        fwd_rdy = 3'b011; fwd_data[31:0] = 32'h3C;
        #1 check("t2_ready_ch0", {63'd0, issue_ready}, 64'd1);
        push(32'h3C, 32'd0, 1'b0, 5'd0);
        cyc();
        idle();
        cyc();
        check("t2_pend5", {62'd0, dut.pending_reg[5]}, 64'd1);

        // retire bypass
        instr_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd7;
        push(32'd0, 32'd0, 1'b1, 5'd7);
        cyc();
        idle();
        instr_valid = 1'b1; rs_en = 2'b10; rs_addr[9:5] = 5'd7;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        #1 check("t3_issue_ready", {63'd0, issue_ready}, 64'd1);
        push(32'd0, 32'h1234, 1'b0, 5'd0);
        cyc();
        idle();
        #1 check("t3_pend7", {62'd0, dut.pending_reg[7]}, 64'd0);
        check("t3_rf7", {32'd0, dut.rf_reg[7]}, 64'h1234);
        cyc();

        // saturating pending counter on x9
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd9;
            #1 check("t4_issue_ready", {63'd0, issue_ready}, 64'd1);
            if (i > 0) check("t4_no_bubble", {63'd0, ex_valid}, 64'd1);
            push(32'd0, 32'd0, 1'b1, 5'd9);
            cyc();
        end
        #1 check("t4_full_stall", {63'd0, issue_ready}, 64'd0);
        check("t4_pend9_full", {62'd0, dut.pending_reg[9]}, 64'd3);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1 check("t4_wb_still_stall", {63'd0, issue_ready}, 64'd0);
        cyc();
        wb_en = 1'b0;
        #1 check("t4_pend9_after_wb", {62'd0, dut.pending_reg[9]}, 64'd2);
        check("t4_fourth_ready", {63'd0, issue_ready}, 64'd1);
        push(32'd0, 32'd0, 1'b1, 5'd9);
        cyc();
        idle();
        #1 check("t4_pend9_refill", {62'd0, dut.pending_reg[9]}, 64'd3);
        cyc();

        // EX backpressure then flush
        instr_valid = 1'b1; rs_en = 2'b01; rs_addr[4:0] = 5'd7; rd_en = 1'b1; rd_addr = 5'd11;
        push(32'h1234, 32'd0, 1'b1, 5'd11);
        cyc();
        rs_en = 2'b00; rd_addr = 5'd12; ex_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("t5_hold_stall", {63'd0, issue_ready}, 64'd0);
            check("t5_hold_valid", {63'd0, ex_valid}, 64'd1);
            check("t5_hold_src0", {32'd0, ex_src[31:0]}, 64'h1234);
            check("t5_hold_rd", {59'd0, ex_rd_addr}, 64'd11);
            cyc();
        end
        check("t5_pend11", {62'd0, dut.pending_reg[11]}, 64'd1);
        instr_valid = 1'b0; flush = 1'b1;
        #1 check("t5_flush_stall", {63'd0, issue_ready}, 64'd0);
        cyc();
        void'(sb.pop_front());
        check("t5_flush_valid", {63'd0, ex_valid}, 64'd0);
        check("t5_flush_pend11", {62'd0, dut.pending_reg[11]}, 64'd0);
        idle();
        cyc();

        // kill + retire + new writer on x3, then async reset mid-stall
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd3;
            push(32'd0, 32'd0, 1'b1, 5'd3);
            cyc();
        end
        check("t6_pend3_two", {62'd0, dut.pending_reg[3]}, 64'd2);
        kill_en = 1'b1; kill_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
        #1 check("t6_issue_ready", {63'd0, issue_ready}, 64'd1);
        push(32'd0, 32'd0, 1'b1, 5'd3);
        cyc();
        check("t6_pend3_net", {62'd0, dut.pending_reg[3]}, 64'd1);
        idle();
        ex_ready = 1'b0;
        cyc();
        check("t6_stalled_valid", {63'd0, ex_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1 check("t6_rst_valid", {63'd0, ex_valid}, 64'd0);
        check("t6_rst_src", {32'd0, ex_src}, 64'd0);
        check("t6_rst_rd", {58'd0, ex_rd_en, ex_rd_addr}, 64'd0);
        check("t6_rst_pend3", {62'd0, dut.pending_reg[3]}, 64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        cyc();

        // register file cleared by reset
        instr_valid = 1'b1; rs_en = 2'b01; rs_addr[4:0] = 5'd7;
        #1 check("t7_issue_ready", {63'd0, issue_ready}, 64'd1);
        push(32'd0, 32'd0, 1'b0, 5'd0);
        cyc();
        idle();
        cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
